// File: rtl/wash_pkg.sv
// Shared phase encoding and helpers for the wash_ctrl_gen2 sequencer.
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_FILL    = 3'd1,
    PH_WASH    = 3'd2,
    PH_RINSE   = 3'd3,
    PH_SPIN    = 3'd4,
    PH_PREWASH = 3'd5
  } phase_t;

  // A request of 0 still runs one iteration; anything above the limit is capped.
  function automatic logic [7:0] clamp_iter(input logic [7:0] req,
                                            input logic [7:0] max_iter);
    logic [7:0] r;
    if (req == 8'd0)
      r = 8'd1;
    else if (req > max_iter)
      r = max_iter;
    else
      r = req;
    return r;
  endfunction

  // IDLE maps to 1 so that "duration-1" loads a zero timer.
  function automatic logic [31:0] phase_dur(input phase_t ph,
                                            input int fill_t,
                                            input int wash_t,
                                            input int rinse_t,
                                            input int spin_t,
                                            input int prewash_t);
    logic [31:0] d;
    case (ph)
      PH_FILL:    d = 32'(fill_t);
      PH_WASH:    d = 32'(wash_t);
      PH_RINSE:   d = 32'(rinse_t);
      PH_SPIN:    d = 32'(spin_t);
      PH_PREWASH: d = 32'(prewash_t);
      default:    d = 32'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable phase down-counter; stops at zero and freezes while hold is high.
module wash_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk_fsm,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               hold,
  output logic               zero,
  output logic [TIMER_W-1:0] count
);

  assign zero = (count == '0);

  always_ff @(posedge clk_fsm or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (!hold && !zero)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/wash_ctrl_gen2.sv
// Coin-started wash sequencer: FILL -> (WASH -> RINSE) x N -> SPIN with an internal timer.
// Optional prewash phase after FILL is enabled by defining WASH_CTRL_PREWASH_EN.
module wash_ctrl_gen2
  import wash_pkg::*;
#(
  parameter int TIMER_W    = 16,
  parameter int FILL_T     = 100,
  parameter int WASH_T     = 300,
  parameter int RINSE_T    = 200,
  parameter int SPIN_T     = 150,
  parameter int PREWASH_T  = 120,
  parameter int COIN_PRICE = 1,
  parameter int MAX_WASH   = 2,
  parameter int CNT_W      = 2
) (
  input  logic               clk_fsm,
  input  logic               rst,
  input  logic               coin_in,
  input  logic [CNT_W-1:0]   wash_count,
  input  logic               pause,
  output logic [2:0]         phase,
  output logic               busy,
  output logic               paused,
  output logic [CNT_W-1:0]   wash_iter,
  output logic [TIMER_W-1:0] time_left,
  output logic               wash_done
);

  localparam int CRED_W = (COIN_PRICE < 2) ? 1 : $clog2(COIN_PRICE + 1);

  phase_t             ph_q, ph_d;
  logic [CRED_W-1:0]  credit_q, credit_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic               done_q, done_d;
  logic               tmr_load, tmr_zero, advance;
  logic [TIMER_W-1:0] tmr_val, tmr_cnt;
  logic [7:0]         target_clamped;
  logic [31:0]        dur_next;

  assign advance        = tmr_zero & ~pause;
  assign target_clamped = clamp_iter(8'(wash_count), 8'(MAX_WASH));
  assign dur_next       = phase_dur(ph_d, FILL_T, WASH_T, RINSE_T, SPIN_T, PREWASH_T);
  assign tmr_val        = TIMER_W'(dur_next - 32'd1);

  wash_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk_fsm  (clk_fsm),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .hold     (pause),
    .zero     (tmr_zero),
    .count    (tmr_cnt)
  );

  always_ff @(posedge clk_fsm or posedge rst) begin
    if (rst) begin
      ph_q     <= PH_IDLE;
      credit_q <= '0;
      iter_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      credit_q <= credit_d;
      iter_q   <= iter_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    ph_d     = ph_q;
    credit_d = credit_q;
    iter_d   = iter_q;
    target_d = target_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    case (ph_q)
      PH_IDLE: begin
        if (coin_in) begin
          if (int'(credit_q) + 1 >= COIN_PRICE) begin
            credit_d = '0;
            target_d = target_clamped[CNT_W-1:0];
            ph_d     = PH_FILL;
            tmr_load = 1'b1;
          end else begin
            credit_d = credit_q + 1'b1;
          end
        end
      end
      PH_FILL: begin
        if (advance) begin
`ifdef WASH_CTRL_PREWASH_EN
          ph_d   = PH_PREWASH;
`else
          ph_d   = PH_WASH;
          iter_d = CNT_W'(1);
`endif
          tmr_load = 1'b1;
        end
      end
`ifdef WASH_CTRL_PREWASH_EN
      PH_PREWASH: begin
        if (advance) begin
          ph_d     = PH_WASH;
          iter_d   = CNT_W'(1);
          tmr_load = 1'b1;
        end
      end
`endif
      PH_WASH: begin
        if (advance) begin
          ph_d     = PH_RINSE;
          tmr_load = 1'b1;
        end
      end
      PH_RINSE: begin
        if (advance) begin
          if (iter_q < target_q) begin
            ph_d   = PH_WASH;
            iter_d = iter_q + 1'b1;
          end else begin
            ph_d   = PH_SPIN;
          end
          tmr_load = 1'b1;
        end
      end
      PH_SPIN: begin
        if (advance) begin
          ph_d     = PH_IDLE;
          iter_d   = '0;
          target_d = '0;
          done_d   = 1'b1;
          tmr_load = 1'b1;
        end
      end
      // Unused codes fall back to IDLE silently, with no completion pulse.
      default: begin
        ph_d     = PH_IDLE;
        iter_d   = '0;
        target_d = '0;
        credit_d = '0;
        tmr_load = 1'b1;
      end
    endcase
  end

  assign phase     = ph_q;
  assign busy      = (ph_q != PH_IDLE);
  assign paused    = busy & pause;
  assign wash_iter = iter_q;
  assign time_left = tmr_cnt;
  assign wash_done = done_q;

endmodule

// File: tb/tb_wash_ctrl_gen2.sv
// Directed bench for wash_ctrl_gen2: per-cycle vector tables plus corner-case sequences.
module tb_wash_ctrl_gen2;

  localparam int P_IDLE = 0, P_FILL = 1, P_WASH = 2, P_RINSE = 3, P_SPIN = 4, P_PRE = 5;
`ifdef WASH_CTRL_PREWASH_EN
  localparam int PW = 2;
`else
  localparam int PW = 0;
`endif

  logic       clk_fsm = 1'b0;
  logic       rst = 1'b1;
  logic       coin_in = 1'b0;
  logic [1:0] wash_count = 2'd0;
  logic       pause = 1'b0;
  logic [2:0] phase;
  logic       busy, paused, wash_done;
  logic [1:0] wash_iter;
  logic [7:0] time_left;

  int n_pass = 0;
  int n_total = 0;

  wash_ctrl_gen2 #(
    .TIMER_W(8), .FILL_T(4), .WASH_T(6), .RINSE_T(3), .SPIN_T(5),
    .PREWASH_T(2), .COIN_PRICE(2), .MAX_WASH(2), .CNT_W(2)
  ) dut (
    .clk_fsm    (clk_fsm),
    .rst        (rst),
    .coin_in    (coin_in),
    .wash_count (wash_count),
    .pause      (pause),
    .phase      (phase),
    .busy       (busy),
    .paused     (paused),
    .wash_iter  (wash_iter),
    .time_left  (time_left),
    .wash_done  (wash_done)
  );

  always #5 clk_fsm = ~clk_fsm;

  typedef struct {
    logic       coin;
    logic [1:0] wc;
    logic [2:0] ph;
    logic [1:0] iter;
    logic [7:0] tl;
    logic       done;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_fsm);
    #1;
  endtask

  function automatic void add_v(input logic coin, input logic [1:0] wc, input int ph,
                                input int iter, input int tl, input logic done);
    vec_t v;
    v.coin = coin; v.wc = wc; v.ph = 3'(ph); v.iter = 2'(iter); v.tl = 8'(tl); v.done = done;
    vq.push_back(v);
  endfunction

  function automatic void add_phase(input logic first_coin, input logic [1:0] wc,
                                    input int ph, input int dur, input int iter);
    for (int k = dur - 1; k >= 0; k--)
      add_v((k == dur - 1) ? first_coin : 1'b0, wc, ph, iter, k, 1'b0);
  endfunction

  function automatic void add_job(input logic [1:0] wc, input int iters);
    add_v(1'b1, wc, P_IDLE, 0, 0, 1'b0);
    add_phase(1'b1, wc, P_FILL, 4, 0);
`ifdef WASH_CTRL_PREWASH_EN
    add_phase(1'b0, wc, P_PRE, 2, 0);
`endif
    for (int i = 1; i <= iters; i++) begin
      add_phase(1'b0, wc, P_WASH, 6, i);
      add_phase(1'b0, wc, P_RINSE, 3, i);
    end
    add_phase(1'b0, wc, P_SPIN, 5, iters);
    add_v(1'b0, wc, P_IDLE, 0, 0, 1'b1);
    add_v(1'b0, wc, P_IDLE, 0, 0, 1'b0);
  endfunction

  // Runs a started job to IDLE; optionally pauses 3 cycles on the last WASH cycle.
  task automatic run_job(input logic do_pause, output int n_busy, output int n_done,
                         output int max_iter);
    int pcnt = 0;
    n_busy = 0; n_done = 0; max_iter = 0;
    while (busy && n_busy < 200) begin
      n_busy++;
      if (int'(wash_iter) > max_iter) max_iter = int'(wash_iter);
      if (do_pause && phase == 3'(P_WASH) && time_left == 8'd0 && pcnt < 3) begin
        pause = 1'b1;
        pcnt++;
      end else begin
        pause = 1'b0;
      end
      step();
      if (pause) chk("pause_hold", {29'd0, paused, phase == 3'(P_WASH), time_left == 8'd0}, 32'h7);
      if (wash_done) n_done++;
    end
    pause = 1'b0;
    chk("job_bound", 32'(n_busy < 200), 32'd1);
  endtask

  task automatic start_job(input logic [1:0] wc);
    wash_count = wc;
    coin_in = 1'b1;
    step();
    step();
    coin_in = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    int nb, nd, mi, guard;

    add_job(2'd1, 1);
    add_job(2'd2, 2);
    add_job(2'd3, 2);

    #12;
    chk("rst_outputs", {phase, busy, paused, wash_iter, time_left, wash_done}, 32'h0);
    coin_in = 1'b1; pause = 1'b1;
    step();
    chk("rst_held", {phase, busy, paused, wash_iter, time_left, wash_done}, 32'h0);
    coin_in = 1'b0; pause = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_pause_noeffect", {phase, busy, paused}, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      coin_in = vq[i].coin;
      wash_count = vq[i].wc;
      pause = 1'b0;
      step();
      chk($sformatf("vec%0d", i),
          {phase, busy, paused, wash_iter, time_left, wash_done},
          {vq[i].ph, vq[i].ph != 3'd0, 1'b0, vq[i].iter, vq[i].tl, vq[i].done});
    end
    coin_in = 1'b0;

    start_job(2'd0);
    run_job(1'b0, nb, nd, mi);
    chk("wc0_busy", 32'(nb), 32'(18 + PW));
    chk("wc0_done", 32'(nd), 32'd1);
    chk("wc0_iter", 32'(mi), 32'd1);

    start_job(2'd3);
    run_job(1'b0, nb, nd, mi);
    chk("wc3_busy", 32'(nb), 32'(27 + PW));
    chk("wc3_iter", 32'(mi), 32'd2);

    start_job(2'd1);
    run_job(1'b1, nb, nd, mi);
    chk("pause_busy", 32'(nb), 32'(21 + PW));
    chk("pause_done", 32'(nd), 32'd1);

    step();
    coin_in = 1'b1;
    step();
    coin_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("one_coin_idle", 32'(busy), 32'd0);
    end
    coin_in = 1'b1;
    step();
    coin_in = 1'b0;
    chk("second_coin_start", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      coin_in = 1'b1;
      step();
      coin_in = 1'b0;
      step();
    end
    run_job(1'b0, nb, nd, mi);
    chk("coin_job_busy", 32'(nb), 32'(12 + PW));
    chk("done_cycle", 32'(wash_done), 32'd1);
    coin_in = 1'b1;
    step();
    chk("coin_on_done_idle", {phase, busy, wash_done}, 32'h0);
    step();
    coin_in = 1'b0;
    chk("coin_on_done_start", {phase, busy}, {3'(P_FILL), 1'b1});
    run_job(1'b0, nb, nd, mi);

    step();
    wash_count = 2'd2;
    coin_in = 1'b1;
    step();
    step();
    coin_in = 1'b0;
    guard = 0;
    while (!(phase == 3'(P_RINSE) && wash_iter == 2'd1) && guard < 50) begin
      step();
      guard++;
    end
    chk("reach_rinse", 32'(guard < 50), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {phase, busy, paused, wash_iter, time_left, wash_done}, 32'h0);
    #1 rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (wash_done) nd++;
    end
    chk("rst_no_done", 32'(nd), 32'd0);
    coin_in = 1'b1;
    step();
    coin_in = 1'b0;
    chk("rst_credit_lost", 32'(busy), 32'd0);
    coin_in = 1'b1;
    step();
    coin_in = 1'b0;
    chk("rst_restart", 32'(busy), 32'd1);
    run_job(1'b0, nb, nd, mi);
    chk("rst_restart_busy", 32'(nb), 32'(27 + PW));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
